// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
//   ST_*    : arbiter FSM state codes (also visible on the fsm_state debug output)
//   OWN_*   : owner / winner codes for the two requesters
//   ARB_*   : arbitration mode values for the ARB_MODE parameter
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker.
//   if_req, d_req : qualified requests from the two requesters
//   last          : owner code of the most recently arbitrated requester
//   win           : owner code of the winner (meaningful only when a request is present)
// ARB_MODE selects fixed priority (D beats IF) or round-robin on a tie.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic if_req,
  input  logic d_req,
  input  logic last,
  output logic win
);

  always_comb begin
    win = OWN_IF;
    if (if_req && d_req) begin
      if (ARB_MODE == ARB_FIXED) win = OWN_D;
      else                       win = (last == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      win = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (if_*) and load/store (d_*)
// requesters. One transaction is outstanding at a time; every transaction is bounded by a
// timeout that returns an error response instead of hanging the core.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_req/if_addr                  : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_err: fetch accept pulse, response pulse, data, error pulse
//   d_req/d_we/d_be/d_addr/d_wdata  : data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata/d_err    : as the fetch side; stores also return d_rvalid
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : registered request towards memory
//   mem_gnt/mem_rvalid/mem_rdata    : memory accept, response and read data
//   fsm_state                       : debug copy of the arbiter state
//
// Handshakes: a requester raises x_req with stable payload and keeps it until it sees x_gnt;
// mem_req is held with stable mem_* until a cycle with mem_gnt high, which is the transfer.
// mem_rvalid is a one-cycle response with no back-pressure. All outputs are registered, so
// every grant/response pulse appears the cycle after the memory-side event.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  fsm_state
);

  localparam bit            TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      state, state_nxt;
  logic            owner, last, win;
  logic [TO_W-1:0] cnt;
  logic            arb_if, arb_d, arb_go;
  logic            gnt_ev, rsp_ev, err_ev, req_drop, cnt_inc;
  logic            to_hit, to_last;

  // A requester whose gnt is pulsing this cycle is still showing the request that was just
  // accepted; it only gets re-arbitrated once that stale cycle has passed.
  assign arb_if = if_req && !if_gnt;
  assign arb_d  = d_req  && !d_gnt;
  assign arb_go = (state == ST_IDLE) && (arb_if || arb_d);

  assign to_hit  = TO_EN && (cnt == TO_LIMIT);
  assign to_last = TO_EN && (cnt == TO_LAST);

  assign fsm_state = state;

  mem_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .if_req (arb_if),
    .d_req  (arb_d),
    .last   (last),
    .win    (win)
  );

  // Events decoded from the current state; they become registered pulses next cycle.
  always_comb begin
    state_nxt = state;
    gnt_ev    = 1'b0;
    rsp_ev    = 1'b0;
    err_ev    = 1'b0;
    req_drop  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_go) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (to_hit) begin
          // Never granted: the error response carries the missing grant as well.
          gnt_ev    = 1'b1;
          rsp_ev    = 1'b1;
          err_ev    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (mem_gnt) begin
          gnt_ev   = 1'b1;
          req_drop = 1'b1;
          cnt_inc  = 1'b1;
          if (mem_rvalid) begin
            rsp_ev    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_RSP;
          end
        end else begin
          cnt_inc  = 1'b1;
          // Withdraw the request as the count reaches the limit; the abort follows next cycle.
          req_drop = to_last;
        end
      end
      ST_WAIT_RSP: begin
        if (to_hit) begin
          rsp_ev    = 1'b1;
          err_ev    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (mem_rvalid) begin
          rsp_ev    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      last      <= OWN_IF;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      if_gnt    <= gnt_ev && (owner == OWN_IF);
      d_gnt     <= gnt_ev && (owner == OWN_D);
      if_rvalid <= rsp_ev && (owner == OWN_IF);
      d_rvalid  <= rsp_ev && (owner == OWN_D);
      if_err    <= err_ev && (owner == OWN_IF);
      d_err     <= err_ev && (owner == OWN_D);

      if (rsp_ev) begin
        if (owner == OWN_IF) if_rdata <= err_ev ? '0 : mem_rdata;
        else                 d_rdata  <= err_ev ? '0 : mem_rdata;
      end

      if (cnt_inc)  cnt     <= cnt + TO_W'(1);
      if (req_drop) mem_req <= 1'b0;

      if (arb_go) begin
        owner   <= win;
        last    <= win;
        cnt     <= '0;
        mem_req <= 1'b1;
        if (win == OWN_D) begin
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= 4'hF;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
    end
  end

endmodule
